// File: rtl/nvdla_apb2csb_pkg.sv
// Shared definitions for the APB3-to-CSB bridge.
//   state_e          : bridge FSM states
//   TIMEOUT_DEFAULT  : default response timeout in cycles (0 disables it)
//   tmo_width()      : counter width needed to count up to a given limit
package nvdla_apb2csb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WAIT_WR = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int TIMEOUT_DEFAULT = 1023;

    function automatic int tmo_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/nvdla_apb2csb_nb_if.sv
// APB3 completer-side bundle for the NVDLA configuration bridge.
//   psel/penable/pwrite/paddr/pwdata : driven by the APB requester
//   prdata/pready/pslverr            : driven by the bridge
// modport master: SoC/APB fabric side; modport slave: bridge side.
interface nvdla_apb2csb_nb_if #(
    parameter int AW = 32
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/nvdla_apb2csb_tmo.sv
// Response timeout counter for the bridge.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : restart the count at zero (takes priority over en)
//   en         : count one cycle while a CSB transaction is outstanding
//   expired    : count has reached LIMIT; held until the next clr
// With LIMIT = 0 the counter is removed and expired is tied low.
module nvdla_apb2csb_tmo
    import nvdla_apb2csb_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (LIMIT > 0) begin : g_cnt
            localparam int CW = tmo_width(LIMIT);
            localparam logic [CW-1:0] LIM = LIMIT[CW-1:0];

            logic [CW-1:0] cnt;

            // Saturates at LIM so a stalled transaction can never wrap back
            // below the limit before the FSM reacts.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en && (cnt != LIM)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = (cnt == LIM);
        end else begin : g_off
            logic unused_tmo;
            assign unused_tmo = ^{clk, rst_n, clr, en};
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/nvdla_apb2csb_nb.sv
// APB3-to-CSB bridge for the NVDLA configuration port.
// Each APB access is registered and replayed on CSB by a small FSM; the
// APB side completes with a one-cycle pready pulse once the CSB side is done.
//   pclk, prstn          : clock, asynchronous active-low reset
//   apb (slave modport)  : psel/penable/pwrite/paddr/pwdata in,
//                          prdata/pready/pslverr out (all registered)
//   csb2nvdla_*          : CSB request (valid/ready, addr, wdat, write, nposted)
//   nvdla2csb_valid/data : CSB read response
//   nvdla2csb_wr_complete: completion for non-posted writes
// Misaligned or out-of-window addresses and response timeouts are reported
// on pslverr; timed-out reads return zero data.
module nvdla_apb2csb_nb
    import nvdla_apb2csb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int CSB_AW     = 16,
    parameter int NPOSTED_WR = 0,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic              pclk,
    input  logic              prstn,
    nvdla_apb2csb_nb_if.slave apb,
    output logic              csb2nvdla_valid,
    input  logic              csb2nvdla_ready,
    output logic [CSB_AW-1:0] csb2nvdla_addr,
    output logic [31:0]       csb2nvdla_wdat,
    output logic              csb2nvdla_write,
    output logic              csb2nvdla_nposted,
    input  logic              nvdla2csb_valid,
    input  logic [31:0]       nvdla2csb_data,
    input  logic              nvdla2csb_wr_complete
);

    localparam bit NP = (NPOSTED_WR != 0);

    state_e state;
    state_e state_nxt;
    logic   err;
    logic   err_nxt;
    logic   accept;
    logic   addr_bad;
    logic   cap_rd;
    logic   zero_rd;
    logic   tmo_clr;
    logic   tmo_en;
    logic   tmo_expired;

    assign addr_bad = (apb.paddr[1:0] != 2'b00) || (apb.paddr[AW-1:CSB_AW] != '0);
    assign tmo_en   = (state == ST_REQ) || (state == ST_WAIT_RD) || (state == ST_WAIT_WR);

    nvdla_apb2csb_tmo #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk     (pclk),
        .rst_n   (prstn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        accept    = 1'b0;
        cap_rd    = 1'b0;
        zero_rd   = 1'b0;
        tmo_clr   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (apb.psel && apb.penable) begin
                    accept = 1'b1;
                    if (addr_bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        tmo_clr   = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
            end
            // Timeout is checked first so that an expiry abandons the
            // request even when ready arrives in the same cycle.
            ST_REQ: begin
                if (tmo_expired) begin
                    err_nxt   = 1'b1;
                    zero_rd   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (csb2nvdla_ready) begin
                    if (!csb2nvdla_write) begin
                        state_nxt = ST_WAIT_RD;
                    end else if (NP) begin
                        state_nxt = ST_WAIT_WR;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (tmo_expired) begin
                    err_nxt   = 1'b1;
                    zero_rd   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (nvdla2csb_valid) begin
                    cap_rd    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT_WR: begin
                if (tmo_expired) begin
                    err_nxt   = 1'b1;
                    zero_rd   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (nvdla2csb_wr_complete) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                err_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                err_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they belong to without any input-to-output path.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            err               <= 1'b0;
            apb.pready        <= 1'b0;
            apb.pslverr       <= 1'b0;
            apb.prdata        <= '0;
            csb2nvdla_valid   <= 1'b0;
            csb2nvdla_addr    <= '0;
            csb2nvdla_wdat    <= '0;
            csb2nvdla_write   <= 1'b0;
            csb2nvdla_nposted <= 1'b0;
        end else begin
            err             <= err_nxt;
            apb.pready      <= (state_nxt == ST_DONE);
            apb.pslverr     <= (state_nxt == ST_DONE) && err_nxt;
            csb2nvdla_valid <= (state_nxt == ST_REQ);
            if (accept) begin
                csb2nvdla_addr    <= {2'b00, apb.paddr[CSB_AW-1:2]};
                csb2nvdla_wdat    <= apb.pwdata;
                csb2nvdla_write   <= apb.pwrite;
                csb2nvdla_nposted <= apb.pwrite & NP;
            end
            if (cap_rd) begin
                apb.prdata <= nvdla2csb_data;
            end else if (zero_rd) begin
                apb.prdata <= '0;
            end
        end
    end

endmodule
